// File: rtl/alu_result_bcd.sv
// alu_result_bcd: signed ALU result to packed BCD via iterative shift-add-3; option ALU_BCD_LZ_BLANK_EN blanks leading zeros
module alu_result_bcd #(
    parameter int WIDTH  = 12,
    parameter int NARROW = 6,
    parameter int DIGITS = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [WIDTH-1:0]      result_in,
    input  logic [1:0]            op_in,
    input  logic                  overflow_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  sign_out,
    output logic                  err_out,
    output logic                  done_out
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, ABS, SHIFT, DONE} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] value;
    logic [WIDTH-1:0] mag;
    logic [4*DIGITS-1:0] scratch, adj, bcd_ld;
    logic sign_r, err_r;
`ifdef ALU_BCD_LZ_BLANK_EN
    logic lead;
`endif
    // state register
    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else state <= state_nx;
    end
    // next-state and handshake
    always_comb begin
        state_nx  = state;
        ready_out = (state == IDLE);
        case (state)
            IDLE:    state_nx = valid_in ? ABS : IDLE;
            ABS:     state_nx = SHIFT;
            SHIFT:   state_nx = (cnt == CW'(WIDTH-1)) ? DONE : SHIFT;
            default: state_nx = IDLE;
        endcase
    end
    // add 3 to every digit >= 5 ahead of the shift
    always_comb begin
        adj = scratch;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i+:4] = (scratch[4*i+:4] >= 4'd5) ? scratch[4*i+:4] + 4'd3 : scratch[4*i+:4];
    end
    // value loaded at DONE, optionally with leading zeros turned into the blank code
    always_comb begin
        bcd_ld = scratch;
`ifdef ALU_BCD_LZ_BLANK_EN
        lead = 1'b1;
        for (int i = DIGITS-1; i > 0; i--) begin
            lead = lead & (scratch[4*i+:4] == 4'd0);
            if (lead) bcd_ld[4*i+:4] = 4'hF;
        end
`endif
    end
    // capture, absolute value, double-dabble and output load
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bcd_out  <= '0;
            sign_out <= 1'b0;
            err_out  <= 1'b0;
            done_out <= 1'b0;
        end else begin
            done_out <= (state == DONE);
            case (state)
                IDLE: if (valid_in) begin
                    value <= (op_in == 2'b10) ? result_in
                           : {{(WIDTH-NARROW){result_in[NARROW-1]}}, result_in[NARROW-1:0]};
                    err_r <= overflow_in & ~op_in[1];
                end
                ABS: begin
                    sign_r  <= value[WIDTH-1];
                    // unsigned magnitude: the most negative value maps to 2^(WIDTH-1) without wrapping
                    mag     <= value[WIDTH-1] ? -value : value;
                    scratch <= '0;
                    cnt     <= '0;
                end
                SHIFT: begin
                    {scratch, mag} <= {adj, mag} << 1;
                    cnt <= cnt + 1'b1;
                end
                default: begin
                    bcd_out  <= bcd_ld;
                    sign_out <= sign_r & (|scratch);
                    err_out  <= err_r;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_result_bcd.sv
// tb_alu_result_bcd: directed checks of alu_result_bcd latency, conversion, sign/err, handshake and reset
module tb_alu_result_bcd;
    logic clk = 1'b0;
    logic rst_in = 1'b1;
    logic [11:0] result_in = '0;
    logic [1:0] op_in = '0;
    logic overflow_in = 1'b0;
    logic valid_in = 1'b0;
    logic ready_out, sign_out, err_out, done_out;
    logic [15:0] bcd_out;
    int vecs = 0;
    int bad = 0;
    int dones;
    int lat;

    alu_result_bcd dut (
        .clk_in(clk), .rst_in(rst_in), .result_in(result_in), .op_in(op_in),
        .overflow_in(overflow_in), .valid_in(valid_in), .ready_out(ready_out),
        .bcd_out(bcd_out), .sign_out(sign_out), .err_out(err_out), .done_out(done_out)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lz(input logic [15:0] b);
        logic [15:0] r;
`ifdef ALU_BCD_LZ_BLANK_EN
        logic lead;
`endif
        r = b;
`ifdef ALU_BCD_LZ_BLANK_EN
        lead = 1'b1;
        for (int i = 3; i > 0; i--) begin
            lead = lead & (b[4*i+:4] == 4'd0);
            if (lead) r[4*i+:4] = 4'hF;
        end
`endif
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag);
        lat = 0;
        while (done_out !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'd14);
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic [11:0] res, input logic ovf,
                       input logic [15:0] eb, input logic es, input logic ee);
        @(negedge clk);
        op_in = op; result_in = res; overflow_in = ovf; valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        result_in = 12'($urandom);
        check({tag, ".busy"}, 32'(ready_out), 32'd0);
        wait_done(tag);
        check({tag, ".bcd"}, 32'(bcd_out), 32'(lz(eb)));
        check({tag, ".sign"}, 32'(sign_out), 32'(es));
        check({tag, ".err"}, 32'(err_out), 32'(ee));
        @(negedge clk);
        check({tag, ".pulse"}, 32'(done_out), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.ready", 32'(ready_out), 32'd1);
        check("rst.bcd", 32'(bcd_out), 32'd0);
        check("rst.sign", 32'(sign_out), 32'd0);
        check("rst.err", 32'(err_out), 32'd0);
        check("rst.done", 32'(done_out), 32'd0);
        rst_in = 1'b0;

        run("add_m3",    2'b00, 12'h03D, 1'b0, 16'h0003, 1'b1, 1'b0);
        run("mul_m2048", 2'b10, 12'h800, 1'b0, 16'h2048, 1'b1, 1'b0);
        run("mul_2047",  2'b10, 12'h7FF, 1'b0, 16'h2047, 1'b0, 1'b0);
        run("add_ovf",   2'b00, 12'h020, 1'b1, 16'h0032, 1'b1, 1'b1);
        run("mul_ovf",   2'b10, 12'h005, 1'b1, 16'h0005, 1'b0, 1'b0);
        run("sub_31",    2'b01, 12'h01F, 1'b0, 16'h0031, 1'b0, 1'b0);
        run("div_rem",   2'b11, 12'hFC0, 1'b1, 16'h0000, 1'b0, 1'b0);
        run("div_zero",  2'b11, 12'h000, 1'b0, 16'h0000, 1'b0, 1'b0);
        run("mul_100",   2'b10, 12'h064, 1'b0, 16'h0100, 1'b0, 1'b0);
        run("mul_m1",    2'b10, 12'hFFF, 1'b0, 16'h0001, 1'b1, 1'b0);
        run("mul_m1000", 2'b10, 12'hC18, 1'b0, 16'h1000, 1'b1, 1'b0);

        // valid held high with changing data during a conversion
        @(negedge clk);
        op_in = 2'b10; result_in = 12'h0C8; overflow_in = 1'b0; valid_in = 1'b1;
        @(posedge clk);
        dones = 0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (done_out) dones++;
            if (c == 5) check("hold.busy", 32'(ready_out), 32'd0);
            if (c < 15) begin
                result_in = 12'($urandom);
                op_in = 2'($urandom);
                overflow_in = 1'($urandom);
            end
        end
        check("hold.dones", 32'(dones), 32'd1);
        check("hold.bcd", 32'(bcd_out), 32'(lz(16'h0200)));
        check("hold.sign", 32'(sign_out), 32'd0);
        check("hold.err", 32'(err_out), 32'd0);
        check("hold.ready", 32'(ready_out), 32'd1);
        op_in = 2'b00; result_in = 12'h001; overflow_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        check("hold2.busy", 32'(ready_out), 32'd0);
        wait_done("hold2");
        check("hold2.bcd", 32'(bcd_out), 32'(lz(16'h0001)));
        check("hold2.sign", 32'(sign_out), 32'd0);

        run("sub_ovf", 2'b01, 12'hAE0, 1'b1, 16'h0032, 1'b1, 1'b1);

        // reset in the middle of a conversion
        @(negedge clk);
        op_in = 2'b10; result_in = 12'h7FF; overflow_in = 1'b0; valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        repeat (4) @(negedge clk);
        rst_in = 1'b1;
        @(negedge clk);
        rst_in = 1'b0;
        check("abort.ready", 32'(ready_out), 32'd1);
        check("abort.bcd", 32'(bcd_out), 32'd0);
        check("abort.sign", 32'(sign_out), 32'd0);
        check("abort.err", 32'(err_out), 32'd0);
        check("abort.done", 32'(done_out), 32'd0);
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_out) dones++;
        end
        check("abort.nodone", 32'(dones), 32'd0);

        // reset and valid in the same cycle drops the result
        @(negedge clk);
        rst_in = 1'b1; valid_in = 1'b1; op_in = 2'b10; result_in = 12'h7FF;
        @(negedge clk);
        rst_in = 1'b0; valid_in = 1'b0;
        check("rstv.ready", 32'(ready_out), 32'd1);
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_out) dones++;
        end
        check("rstv.nodone", 32'(dones), 32'd0);
        check("rstv.bcd", 32'(bcd_out), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
        $finish;
    end
endmodule
